// File: rtl/ex_stage_mdu_if.sv
// ex_stage_mdu_if: bundle between the ID/EX register / hazard unit side (master)
// and the execute stage (slave).
//   ID/EX side -> EX : ex_valid, flush, decoded controls, alu_op, shamt,
//                      fwd_a/fwd_b selects, operand data, register indices, pc_e
//   EX -> hazard/MEM : dest_e, stall, mdu_busy and the EX/MEM register outputs
interface ex_stage_mdu_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int PCW   = 32
) ();
  logic             ex_valid, flush;
  logic             reg_write, mem_read, mem_write, mem_to_reg, jal, reg_dst, alu_src;
  logic [3:0]       alu_op;
  logic [4:0]       shamt;
  logic [1:0]       fwd_a, fwd_b;
  logic [WIDTH-1:0] rs_data, rt_data, imm, wb_data, mem_data;
  logic [REGW-1:0]  rt_idx, rd_idx;
  logic [PCW-1:0]   pc_e;

  logic             stall, mdu_busy;
  logic [REGW-1:0]  dest_e;
  logic             reg_write_m, mem_read_m, mem_write_m, mem_to_reg_m, jal_m;
  logic [WIDTH-1:0] alu_result_m, store_data_m;
  logic [REGW-1:0]  dest_m;
  logic [PCW-1:0]   pc_m;

  modport slave (
    input  ex_valid, flush, reg_write, mem_read, mem_write, mem_to_reg, jal,
           reg_dst, alu_src, alu_op, shamt, fwd_a, fwd_b, rs_data, rt_data, imm,
           wb_data, mem_data, rt_idx, rd_idx, pc_e,
    output stall, mdu_busy, dest_e, reg_write_m, mem_read_m, mem_write_m,
           mem_to_reg_m, jal_m, alu_result_m, store_data_m, dest_m, pc_m
  );

  modport master (
    output ex_valid, flush, reg_write, mem_read, mem_write, mem_to_reg, jal,
           reg_dst, alu_src, alu_op, shamt, fwd_a, fwd_b, rs_data, rt_data, imm,
           wb_data, mem_data, rt_idx, rd_idx, pc_e,
    input  stall, mdu_busy, dest_e, reg_write_m, mem_read_m, mem_write_m,
           mem_to_reg_m, jal_m, alu_result_m, store_data_m, dest_m, pc_m
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage with operand forwarding, single-cycle ALU and an
// iterative multiply/divide unit, ending in the EX/MEM pipeline register.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - ex_stage_mdu_if.slave (ID/EX inputs, stall/dest_e to hazard unit,
//           EX/MEM register outputs)
// MULU/DIVU/REMU run as IDLE -> BUSY (WIDTH steps) -> DONE; stall is held from
// the IDLE cycle that accepts the op until the last BUSY cycle.
module ex_stage_mdu #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int PCW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  ex_stage_mdu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,
                         OP_OR   = 4'd3,  OP_XOR  = 4'd4,  OP_NOR  = 4'd5,
                         OP_SLT  = 4'd6,  OP_SLTU = 4'd7,  OP_SLL  = 4'd8,
                         OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_LUI  = 4'd11,
                         OP_MULU = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // MULU: acc = product, a = shifted multiplicand, b = shifted multiplier.
  // DIVU/REMU: acc = partial remainder, a = divisor, b = dividend/quotient.
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;

  logic             reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, jal_q;
  logic             reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, jal_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d, store_data_q, store_data_d;
  logic [REGW-1:0]  dest_q, dest_d;
  logic [PCW-1:0]   pc_q, pc_d;

  logic [WIDTH-1:0] op_a, fwd_rt, op_b, alu_res, mdu_res, ex_res;
  logic [SHW-1:0]   sh;
  logic             is_mdu, stall, load;
  logic [WIDTH:0]   rem_sh;

  // ---------------- forwarding / operand select ----------------
  always_comb begin
    case (bus.fwd_a)
      2'b01:   op_a = bus.wb_data;
      2'b10:   op_a = bus.mem_data;
      default: op_a = bus.rs_data;
    endcase
    case (bus.fwd_b)
      2'b01:   fwd_rt = bus.wb_data;
      2'b10:   fwd_rt = bus.mem_data;
      default: fwd_rt = bus.rt_data;
    endcase
    op_b = bus.alu_src ? bus.imm : fwd_rt;
  end

  assign is_mdu = (bus.alu_op == OP_MULU) || (bus.alu_op == OP_DIVU) ||
                  (bus.alu_op == OP_REMU);
  assign sh     = SHW'(32'(bus.shamt) % WIDTH);

  // ---------------- single-cycle ALU ----------------
  // Shifts operate on B (the rt/imm operand), MIPS style.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_res = op_b << sh;
      OP_SRL:  alu_res = op_b >> sh;
      OP_SRA:  alu_res = $signed(op_b) >>> sh;
      OP_LUI:  alu_res = bus.imm << 16;
      4'd15:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // ---------------- MDU FSM: next state + datapath ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_sh  = {acc_q, b_q[WIDTH-1]};
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.ex_valid && is_mdu) begin
          state_d = S_BUSY;
          cnt_d   = CW'(WIDTH);
          op_d    = bus.alu_op;
          acc_d   = '0;
          a_d     = (bus.alu_op == OP_MULU) ? op_a : op_b;
          b_d     = (bus.alu_op == OP_MULU) ? op_b : op_a;
        end
        S_BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
          if (op_q == OP_MULU) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else if (rem_sh >= {1'b0, a_q}) begin
            // restoring step; divisor 0 always "fits", giving all-ones
            // quotient and the dividend as remainder
            acc_d = WIDTH'(rem_sh - {1'b0, a_q});
            b_d   = {b_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[WIDTH-1:0];
            b_d   = {b_q[WIDTH-2:0], 1'b0};
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- MDU FSM: outputs ----------------
  // stall is built from state and decoded op only, never from fwd_*.
  always_comb begin
    stall   = !bus.flush &&
              (((state_q == S_IDLE) && bus.ex_valid && is_mdu) || (state_q == S_BUSY));
    mdu_res = (op_q == OP_DIVU) ? b_q : acc_q;
    ex_res  = (state_q == S_DONE) ? mdu_res : alu_res;
  end

  // ---------------- EX/MEM register input ----------------
  always_comb begin
    load         = bus.ex_valid && !stall && !bus.flush;
    reg_write_d  = load & bus.reg_write;
    mem_read_d   = load & bus.mem_read;
    mem_write_d  = load & bus.mem_write;
    mem_to_reg_d = load & bus.mem_to_reg;
    jal_d        = load & bus.jal;
    // bubbles keep the previous data fields
    alu_result_d = load ? ex_res    : alu_result_q;
    store_data_d = load ? fwd_rt    : store_data_q;
    dest_d       = load ? bus.dest_e : dest_q;
    pc_d         = load ? bus.pc_e  : pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      jal_q        <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      dest_q       <= '0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      jal_q        <= jal_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      dest_q       <= dest_d;
      pc_q         <= pc_d;
    end
  end

  assign bus.dest_e       = bus.reg_dst ? bus.rd_idx : bus.rt_idx;
  assign bus.stall        = stall;
  assign bus.mdu_busy     = (state_q == S_BUSY);
  assign bus.reg_write_m  = reg_write_q;
  assign bus.mem_read_m   = mem_read_q;
  assign bus.mem_write_m  = mem_write_q;
  assign bus.mem_to_reg_m = mem_to_reg_q;
  assign bus.jal_m        = jal_q;
  assign bus.alu_result_m = alu_result_q;
  assign bus.store_data_m = store_data_q;
  assign bus.dest_m       = dest_q;
  assign bus.pc_m         = pc_q;

endmodule
